sr_cmd_gen: RTL and testbench
=============================

Name: sr_cmd_gen

Overview:
- Upstream command stage for the SR flip-flop storage cell.
- Converts two noisy, asynchronous request lines (set request, clear request) into clean, single-cycle, mutually exclusive s/r pulses.
- Each request line passes through a 2-flop synchronizer, a debouncer and a rising-edge detector. A pulse/hold-off FSM then drives the outputs.
- The downstream SR storage treats s=r=1 as invalid, so this block must never produce it.

Parameters:
- DEB_CYCLES, 4: consecutive cycles a synchronized input must differ from its debounced value before that value updates. Range 1..255.
- HOLDOFF, 2: idle cycles forced after every output pulse. Range 1..255.
- CONFLICT_MODE, 0: rule for coincident set/clear events. 0 = drop both and flag conflict; 1 = set wins; 2 = clear wins.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- set_in, input, 1: raw set request. Asynchronous, may bounce.
- clr_in, input, 1: raw clear request. Asynchronous, may bounce.
- s, output, 1: set pulse to the SR storage. Registered, 1 cycle wide.
- r, output, 1: reset pulse to the SR storage. Registered, 1 cycle wide.
- busy, output, 1: high in PULSE and HOLD states.
- conflict, output, 1: 1-cycle pulse when a coincident pair is dropped (CONFLICT_MODE=0) or one side is discarded (modes 1/2).
- overrun, output, 1: sticky flag. Set when a new edge arrives on a channel whose pending latch is already full. Cleared only by rst.

Behaviour:
- Reset (async, immediate): clear all sync flops, debounced values, delayed copies, counters, pending latches, state→IDLE. s=r=busy=conflict=overrun=0. Outputs drop without waiting for clk.
- Synchronizer, per channel: sync1<=raw, sync2<=sync1.
- Debounce, per channel: 8-bit counter cnt, stable value db.
  - If sync2==db: cnt<=0.
  - Else if cnt==DEB_CYCLES-1: db<=sync2, cnt<=0.
  - Else: cnt<=cnt+1.
  - A glitch shorter than DEB_CYCLES cycles never changes db.
- Edge detect: db_d<=db; ev = db & ~db_d. Only rising edges generate events; falling edges are ignored.
- Pending latches pend_s, pend_r:
  - Set by ev while state≠IDLE.
  - If the latch is already set when ev arrives: overrun<=1 and the event is dropped.
- FSM candidates: in IDLE, the candidates are cs = ev_s|pend_s and cr = ev_r|pend_r.
- FSM states:
  - IDLE:
    - cs&~cr: s<=1, go PULSE.
    - cr&~cs: r<=1, go PULSE.
    - cs&cr, mode 0: conflict<=1, no pulse, stay IDLE.
    - cs&cr, mode 1: s<=1, conflict<=1, go PULSE.
    - cs&cr, mode 2: r<=1, conflict<=1, go PULSE.
    - Any decision clears both pending latches.
  - PULSE (1 cycle): s<=0, r<=0, load hold counter with HOLDOFF, go HOLD.
  - HOLD: decrement the counter; when it reaches 1, go IDLE.
- Pulse spacing: minimum spacing between pulses is HOLDOFF+2 cycles.
- Latency: a raw level change first sampled at edge k produces a pulse registered at edge k+DEB_CYCLES+2, i.e. DEB_CYCLES+3 edges inclusive. With DEB_CYCLES=4, s is high for the cycle after the 7th edge.
- Invariants: s&r==0 always; s and r are never high for 2 consecutive cycles.
- conflict is high for exactly 1 cycle per event.
- Reset mid-pulse or mid-hold: the pulse is truncated and pending events are lost. After release, the first event is serviced normally.

Test Plan:
- Reset, then set_in 0→1 held, DEB_CYCLES=4, HOLDOFF=2 → s=1 for exactly 1 cycle, 7 edges after the first sampling edge; r=0; busy high for 3 cycles (PULSE + 2 HOLD).
- set_in bounce 1,0,1,0 each 2 cycles, then stable 1 → exactly one s pulse, timed from the final stable rise; no pulse from the bounce.
- set_in and clr_in rise on the same cycle:
  - Mode 0 → conflict 1 cycle, s=r=0.
  - Mode 1 → s pulse plus conflict.
  - Mode 2 → r pulse plus conflict.
- clr edge arrives during HOLD of a set pulse → r pulse issued on the first IDLE cycle after HOLD; overrun stays 0.
- Second clr edge arrives while pend_r is already set → overrun=1 and stays 1 until rst; only one r pulse.
- rst asserted asynchronously mid-cycle while s=1 → s falls before the next clk edge. After release, a new set_in rise yields a normal pulse.

Source files
------------

// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: turns two noisy asynchronous request lines (set, clear) into
// clean, single-cycle, mutually exclusive s/r pulses for an SR storage cell.
// Each channel: 2-flop synchronizer -> debouncer -> rising-edge detector,
// followed by a pulse/hold-off FSM that arbitrates coincident requests.
module sr_cmd_gen #(
   parameter int DEB_CYCLES    = 4,
   parameter int HOLDOFF       = 2,
   parameter int CONFLICT_MODE = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic set_in,
   input  logic clr_in,
   output logic s,
   output logic r,
   output logic busy,
   output logic conflict,
   output logic overrun
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic [7:0] DEB_LAST  = 8'(DEB_CYCLES - 1);
   localparam logic [7:0] HOLD_LOAD = 8'(HOLDOFF);

   // Channel index 0 carries the set request, index 1 the clear request.
   logic [1:0] raw;
   logic [1:0] sync1;
   logic [1:0] sync2;
   logic [1:0] db;
   logic [1:0] db_d;
   logic [1:0] ev;
   logic [1:0] pend;
   logic [1:0] cand;
   logic [7:0] cnt [2];
   logic [7:0] hold_cnt;
   state_t     state;

   assign raw  = {clr_in, set_in};
   assign ev   = db & ~db_d;
   assign cand = ev | pend;
   assign busy = (state != IDLE);

   // Synchronize, debounce and delay both request channels.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1  <= '0;
         sync2  <= '0;
         db     <= '0;
         db_d   <= '0;
         cnt[0] <= '0;
         cnt[1] <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         db_d  <= db;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == db[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == DEB_LAST) begin
               db[i]  <= sync2[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + 8'd1;
            end
         end
      end
   end

   // Pulse/hold-off FSM with pending latches and conflict/overrun flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         s        <= 1'b0;
         r        <= 1'b0;
         conflict <= 1'b0;
         overrun  <= 1'b0;
         pend     <= '0;
         hold_cnt <= '0;
      end else begin
         conflict <= 1'b0;
         overrun  <= overrun | (|(ev & pend));
         case (state)
            IDLE: begin
               pend <= '0;
               if (cand == 2'b01) begin
                  s     <= 1'b1;
                  state <= PULSE;
               end else if (cand == 2'b10) begin
                  r     <= 1'b1;
                  state <= PULSE;
               end else if (cand == 2'b11) begin
                  conflict <= 1'b1;
                  if (CONFLICT_MODE == 1) begin
                     s     <= 1'b1;
                     state <= PULSE;
                  end else if (CONFLICT_MODE == 2) begin
                     r     <= 1'b1;
                     state <= PULSE;
                  end
               end
            end
            PULSE: begin
               s        <= 1'b0;
               r        <= 1'b0;
               hold_cnt <= HOLD_LOAD;
               pend     <= pend | ev;
               state    <= HOLD;
            end
            HOLD: begin
               pend <= pend | ev;
               if (hold_cnt <= 8'd1) begin
                  state <= IDLE;
               end else begin
                  hold_cnt <= hold_cnt - 8'd1;
               end
            end
            default: begin
               s     <= 1'b0;
               r     <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sr_cmd_gen.sv
// tb_sr_cmd_gen: four sr_cmd_gen instances (conflict modes 0/1/2 with a short
// hold-off, plus mode 0 with a long hold-off) driven by shared stimulus and
// compared every cycle against a timestamp-based behavioural model.
module tb_sr_cmd_gen;

   localparam int DEB = 4;
   localparam int NI  = 4;

   logic clk;
   logic rst;
   logic set_in;
   logic clr_in;
   logic [NI-1:0] s_o;
   logic [NI-1:0] r_o;
   logic [NI-1:0] busy_o;
   logic [NI-1:0] conf_o;
   logic [NI-1:0] ovr_o;

   int checks = 0;
   int errors = 0;

   int mode_of [NI] = '{0, 1, 2, 0};
   int hold_of [NI] = '{2, 2, 2, 20};

   sr_cmd_gen #(.DEB_CYCLES(DEB), .HOLDOFF(2), .CONFLICT_MODE(0)) u0 (
      .clk(clk), .rst(rst), .set_in(set_in), .clr_in(clr_in),
      .s(s_o[0]), .r(r_o[0]), .busy(busy_o[0]), .conflict(conf_o[0]), .overrun(ovr_o[0]));
   sr_cmd_gen #(.DEB_CYCLES(DEB), .HOLDOFF(2), .CONFLICT_MODE(1)) u1 (
      .clk(clk), .rst(rst), .set_in(set_in), .clr_in(clr_in),
      .s(s_o[1]), .r(r_o[1]), .busy(busy_o[1]), .conflict(conf_o[1]), .overrun(ovr_o[1]));
   sr_cmd_gen #(.DEB_CYCLES(DEB), .HOLDOFF(2), .CONFLICT_MODE(2)) u2 (
      .clk(clk), .rst(rst), .set_in(set_in), .clr_in(clr_in),
      .s(s_o[2]), .r(r_o[2]), .busy(busy_o[2]), .conflict(conf_o[2]), .overrun(ovr_o[2]));
   sr_cmd_gen #(.DEB_CYCLES(DEB), .HOLDOFF(20), .CONFLICT_MODE(0)) u3 (
      .clk(clk), .rst(rst), .set_in(set_in), .clr_in(clr_in),
      .s(s_o[3]), .r(r_o[3]), .busy(busy_o[3]), .conflict(conf_o[3]), .overrun(ovr_o[3]));

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model state: raw sample history per channel, debounced level and its
   // delayed copy, and per instance the edge number at which it is next idle.
   bit     hist [2][16];
   bit     m_db [2];
   bit     m_dbd [2];
   bit     m_ev [2];
   bit     m_new;
   bit     all_diff;
   bit     cs;
   bit     cr;
   longint n_edge;
   longint idle_at [NI];
   bit     pend [NI][2];
   bit     exp_s [NI];
   bit     exp_r [NI];
   bit     exp_c [NI];
   bit     exp_o [NI];
   bit     exp_b [NI];

   // Behavioural model: a level flips once the synchronized samples have
   // disagreed with it for DEB consecutive edges; each pulse makes the
   // instance unavailable for HOLDOFF+2 edges.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < 2; c++) begin
            for (int j = 0; j < 16; j++) hist[c][j] = 1'b0;
            m_db[c]  = 1'b0;
            m_dbd[c] = 1'b0;
         end
         n_edge = 0;
         for (int i = 0; i < NI; i++) begin
            idle_at[i] = 0;
            pend[i][0] = 1'b0;
            pend[i][1] = 1'b0;
            exp_s[i] = 1'b0;
            exp_r[i] = 1'b0;
            exp_c[i] = 1'b0;
            exp_o[i] = 1'b0;
            exp_b[i] = 1'b0;
         end
      end else begin
         for (int c = 0; c < 2; c++) begin
            m_ev[c] = m_db[c] & ~m_dbd[c];
            all_diff = 1'b1;
            for (int j = 1; j <= DEB; j++) begin
               if (hist[c][j] == m_db[c]) all_diff = 1'b0;
            end
            m_new = all_diff ? ~m_db[c] : m_db[c];
            m_dbd[c] = m_db[c];
            m_db[c]  = m_new;
            for (int j = 15; j > 0; j--) hist[c][j] = hist[c][j-1];
            hist[c][0] = (c == 0) ? set_in : clr_in;
         end
         for (int i = 0; i < NI; i++) begin
            exp_s[i] = 1'b0;
            exp_r[i] = 1'b0;
            exp_c[i] = 1'b0;
            if ((m_ev[0] & pend[i][0]) | (m_ev[1] & pend[i][1])) exp_o[i] = 1'b1;
            if (n_edge >= idle_at[i]) begin
               cs = m_ev[0] | pend[i][0];
               cr = m_ev[1] | pend[i][1];
               pend[i][0] = 1'b0;
               pend[i][1] = 1'b0;
               if (cs && cr) begin
                  exp_c[i] = 1'b1;
                  if (mode_of[i] == 1) exp_s[i] = 1'b1;
                  if (mode_of[i] == 2) exp_r[i] = 1'b1;
               end else begin
                  exp_s[i] = cs;
                  exp_r[i] = cr;
               end
               if (exp_s[i] | exp_r[i]) idle_at[i] = n_edge + hold_of[i] + 2;
            end else begin
               pend[i][0] = pend[i][0] | m_ev[0];
               pend[i][1] = pend[i][1] | m_ev[1];
            end
            exp_b[i] = (n_edge < idle_at[i] - 1);
         end
         n_edge++;
      end
   end

   task automatic check_output(input string name, input int idx, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s inst%0d at %0t: got %b, expected %b", name, idx, $time, got, exp);
      end
   endtask

   // Per-cycle comparison of every instance against the model.
   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NI; i++) begin
            check_output("s", i, s_o[i], exp_s[i]);
            check_output("r", i, r_o[i], exp_r[i]);
            check_output("busy", i, busy_o[i], exp_b[i]);
            check_output("conflict", i, conf_o[i], exp_c[i]);
            check_output("overrun", i, ovr_o[i], exp_o[i]);
            check_output("s_and_r", i, s_o[i] & r_o[i], 1'b0);
         end
      end
   end

   task automatic apply_stimulus(input logic set_v, input logic clr_v, input int cycles);
      set_in = set_v;
      clr_in = clr_v;
      repeat (cycles) @(negedge clk);
   endtask

   int cnt;
   int waited;

   // Directed scenarios with literal expectations, then randomized traffic.
   initial begin
      rst = 1'b1;
      set_in = 1'b0;
      clr_in = 1'b0;
      repeat (3) @(negedge clk);
      check_output("rst_s", 0, s_o[0], 1'b0);
      check_output("rst_busy", 0, busy_o[0], 1'b0);
      check_output("rst_overrun", 3, ovr_o[3], 1'b0);
      rst = 1'b0;
      apply_stimulus(0, 0, 4);

      // Single set rise: pulse on the 7th edge, busy for 3 cycles.
      set_in = 1'b1;
      repeat (6) @(negedge clk);
      check_output("lat_early_s", 0, s_o[0], 1'b0);
      @(negedge clk);
      check_output("lat_s", 0, s_o[0], 1'b1);
      check_output("lat_r", 0, r_o[0], 1'b0);
      check_output("lat_busy1", 0, busy_o[0], 1'b1);
      @(negedge clk);
      check_output("lat_s_drop", 0, s_o[0], 1'b0);
      check_output("lat_busy2", 0, busy_o[0], 1'b1);
      @(negedge clk);
      check_output("lat_busy3", 0, busy_o[0], 1'b1);
      @(negedge clk);
      check_output("lat_busy_end", 0, busy_o[0], 1'b0);
      apply_stimulus(0, 0, 30);

      // Bounce 1,0,1,0 (2 cycles each) then stable high: one pulse only.
      cnt = 0;
      for (int k = 0; k < 4; k++) begin
         set_in = (k % 2 == 0);
         repeat (2) begin
            @(negedge clk);
            cnt += s_o[0];
         end
      end
      set_in = 1'b1;
      repeat (6) begin
         @(negedge clk);
         cnt += s_o[0];
      end
      check_output("bounce_early_s", 0, s_o[0], 1'b0);
      @(negedge clk);
      cnt += s_o[0];
      check_output("bounce_s", 0, s_o[0], 1'b1);
      repeat (12) begin
         @(negedge clk);
         cnt += s_o[0];
      end
      check_output("bounce_count", 0, cnt == 1, 1'b1);
      apply_stimulus(0, 0, 30);

      // Coincident rise on both lines.
      set_in = 1'b1;
      clr_in = 1'b1;
      repeat (7) @(negedge clk);
      check_output("coin_conf_m0", 0, conf_o[0], 1'b1);
      check_output("coin_s_m0", 0, s_o[0], 1'b0);
      check_output("coin_r_m0", 0, r_o[0], 1'b0);
      check_output("coin_s_m1", 1, s_o[1], 1'b1);
      check_output("coin_conf_m1", 1, conf_o[1], 1'b1);
      check_output("coin_r_m2", 2, r_o[2], 1'b1);
      check_output("coin_conf_m2", 2, conf_o[2], 1'b1);
      @(negedge clk);
      check_output("coin_conf_once", 1, conf_o[1], 1'b0);
      apply_stimulus(0, 0, 30);

      // Clear edge lands during HOLD of a set pulse: r on first idle cycle.
      set_in = 1'b1;
      repeat (2) @(negedge clk);
      clr_in = 1'b1;
      repeat (5) @(negedge clk);
      check_output("hold_s", 0, s_o[0], 1'b1);
      repeat (4) @(negedge clk);
      check_output("hold_r", 0, r_o[0], 1'b1);
      check_output("hold_overrun", 0, ovr_o[0], 1'b0);
      apply_stimulus(0, 0, 40);

      // Two clear edges during a long hold-off: overrun and a single r pulse.
      cnt = 0;
      set_in = 1'b1;
      for (int k = 0; k < 70; k++) begin
         if (k == 8) clr_in = 1'b1;
         if (k == 14) clr_in = 1'b0;
         if (k == 20) clr_in = 1'b1;
         @(negedge clk);
         cnt += r_o[3];
      end
      check_output("ovr_flag", 3, ovr_o[3], 1'b1);
      check_output("ovr_one_r", 3, cnt == 1, 1'b1);
      apply_stimulus(0, 0, 20);
      check_output("ovr_sticky", 3, ovr_o[3], 1'b1);

      // Asynchronous reset while s is high.
      set_in = 1'b1;
      waited = 0;
      while (s_o[0] !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check_output("ar_s_seen", 0, s_o[0], 1'b1);
      #2 rst = 1'b1;
      set_in = 1'b0;
      clr_in = 1'b0;
      #1;
      check_output("ar_s_drop", 0, s_o[0], 1'b0);
      check_output("ar_busy_drop", 0, busy_o[0], 1'b0);
      check_output("ar_overrun_clr", 3, ovr_o[3], 1'b0);
      @(negedge clk);
      rst = 1'b0;
      apply_stimulus(0, 0, 10);
      set_in = 1'b1;
      repeat (7) @(negedge clk);
      check_output("ar_after_s", 0, s_o[0], 1'b1);
      apply_stimulus(0, 0, 30);

      // Randomized levels held for random durations (bounces and steady runs).
      for (int k = 0; k < 300; k++) begin
         apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        $urandom_range(1, 10));
      end
      apply_stimulus(0, 0, 40);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
